// File: rtl/pwm_pkg.sv
// Shared mode encodings and the bit-width scaling helper for the PWM waveform generator.
package pwm_pkg;

   localparam logic [1:0] MODE_SINE  = 2'd0;
   localparam logic [1:0] MODE_TRI   = 2'd1;
   localparam logic [1:0] MODE_SAW   = 2'd2;
   localparam logic [1:0] MODE_FIXED = 2'd3;

   // Rescale a src_w-bit code to dst_w bits: widen by left shift, narrow by dropping LSBs.
   function automatic int unsigned scale_shift(input int unsigned v, input int src_w, input int dst_w);
      if (dst_w >= src_w) return v << (dst_w - src_w);
      else                return v >> (src_w - dst_w);
   endfunction

endpackage

// File: rtl/pwm_sine_lut.sv
// Combinational sine table: value = round((2^R-1)*(0.5+0.5*sin(2*pi*k/2^S))), built at elaboration.
module pwm_sine_lut #(
   parameter int R = 6,
   parameter int S = 6
) (
   input  logic [S-1:0] k,
   output logic [R-1:0] value
);

   localparam longint ONE_Q30 = longint'(1) << 30;
   localparam longint PI_HALF = 64'sd1686629713;

   // Fixed-point Q30 Taylor series on the first quadrant, folded by symmetry.
   function automatic logic [R-1:0] sine_entry(input int idx);
      int     q, quad, r, a;
      longint x, x2, term, s, full, v;
      q    = 1 << (S - 2);
      quad = idx / q;
      r    = idx % q;
      a    = (quad == 1 || quad == 3) ? q - r : r;
      x    = (PI_HALF * longint'(a)) / longint'(q);
      x2   = (x * x) >>> 30;
      term = x;
      s    = x;
      for (int n = 1; n <= 6; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
         s    = s + term;
      end
      if (quad >= 2) s = -s;
      full = (longint'(1) << R) - 1;
      v    = full * (ONE_Q30 + s) + ONE_Q30;
      return R'(v >>> 31);
   endfunction

   logic [R-1:0] lut [2**S];

   for (genvar i = 0; i < 2**S; i++) begin : g_lut
      localparam logic [R-1:0] ENTRY = sine_entry(i);
      assign lut[i] = ENTRY;
   end

   assign value = lut[k];

endmodule

// File: rtl/pwm_wave_gen_mc.sv
// Multi-channel PWM generator with phase-offset waveforms and period-shadowed duty.
// Define PWM_COMPL_EN to add the complementary pwm_out_n output with dead-time insertion.
module pwm_wave_gen_mc
   import pwm_pkg::*;
#(
   parameter int R          = 6,
   parameter int S          = 6,
   parameter int C          = 3,
   parameter int PHASE_STEP = 21,
   parameter int DT         = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [1:0]    mode,
   input  logic [15:0]   step_div,
   input  logic [R-1:0]  duty_fixed,
   output logic [C-1:0]  pwm_out,
`ifdef PWM_COMPL_EN
   output logic [C-1:0]  pwm_out_n,
`endif
   output logic          period_tick,
   output logic [S-1:0]  wave_idx
);

   localparam logic [R-1:0] CNT_LAST = '1;

   logic [R-1:0]  cnt_q, cnt_d;
   logic [15:0]   hold_q, hold_d;
   logic [S-1:0]  idx_q, idx_d;
   logic          tick_q, tick_d;
   logic [C-1:0]  pwm_raw_q, pwm_raw_d;
   logic [R-1:0]  duty_q [C];
   logic [R-1:0]  duty_d [C];
   logic [R-1:0]  sample [C];
   logic [16:0]   hold_inc, div_eff;

   for (genvar c = 0; c < C; c++) begin : g_ch
      localparam logic [S-1:0] OFF = S'((c * PHASE_STEP) % (2 ** S));
      logic [S-1:0] k;
      logic [S-2:0] tri_t;
      logic [R-1:0] sine_v, tri_v, saw_v, samp;

      assign k     = idx_q + OFF;
      assign tri_t = k[S-1] ? ~k[S-2:0] : k[S-2:0];
      assign tri_v = R'(scale_shift(32'(tri_t), S - 1, R));
      assign saw_v = R'(scale_shift(32'(k), S, R));

      pwm_sine_lut #(.R(R), .S(S)) u_sine_lut (.k(k), .value(sine_v));

      always_comb begin
         case (mode)
            MODE_SINE: samp = sine_v;
            MODE_TRI:  samp = tri_v;
            MODE_SAW:  samp = saw_v;
            default:   samp = duty_fixed;
         endcase
      end

      assign sample[c] = samp;
   end

   // tick_d marks the edge that enters the last cycle of the period; duty,
   // hold and idx all update on that edge so the new duty is live from cnt=0.
   always_comb begin
      cnt_d    = en ? cnt_q + 1'b1 : '0;
      tick_d   = en && (cnt_q == CNT_LAST - 1'b1);
      div_eff  = (step_div == 16'd0) ? 17'd1 : {1'b0, step_div};
      hold_inc = {1'b0, hold_q} + 17'd1;
      hold_d   = hold_q;
      idx_d    = idx_q;
      if (tick_d) begin
         if (hold_inc >= div_eff) begin
            hold_d = '0;
            idx_d  = idx_q + 1'b1;
         end else begin
            hold_d = hold_inc[15:0];
         end
      end
      for (int c = 0; c < C; c++) begin
         duty_d[c]    = tick_d ? sample[c] : duty_q[c];
         pwm_raw_d[c] = en && (cnt_q < duty_q[c]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         hold_q    <= '0;
         idx_q     <= '0;
         tick_q    <= 1'b0;
         pwm_raw_q <= '0;
         for (int c = 0; c < C; c++) duty_q[c] <= '0;
      end else begin
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         idx_q     <= idx_d;
         tick_q    <= tick_d;
         pwm_raw_q <= pwm_raw_d;
         for (int c = 0; c < C; c++) duty_q[c] <= duty_d[c];
      end
   end

   assign period_tick = tick_q;
   assign wave_idx    = idx_q;

`ifdef PWM_COMPL_EN
   localparam int DW = (DT > 1) ? $clog2(DT + 1) : 1;
   localparam logic [DW-1:0] DT_LOAD = (DT > 0) ? DW'(DT - 1) : '0;

   logic [DW-1:0] dt_q [C];
   logic [DW-1:0] dt_d [C];
   logic [C-1:0]  last_q, last_d, hi_q, hi_d, lo_q, lo_d;

   // Any raw edge blanks both sides and reloads the counter, so pulses
   // shorter than the dead-time never reach the pads.
   always_comb begin
      last_d = pwm_raw_q;
      for (int c = 0; c < C; c++) begin
         if (pwm_raw_q[c] != last_q[c]) dt_d[c] = DT_LOAD;
         else if (dt_q[c] != '0)        dt_d[c] = dt_q[c] - 1'b1;
         else                           dt_d[c] = '0;
         hi_d[c] = (pwm_raw_q[c] == last_q[c]) && (dt_q[c] == '0) && pwm_raw_q[c];
         lo_d[c] = (pwm_raw_q[c] == last_q[c]) && (dt_q[c] == '0) && !pwm_raw_q[c] && en;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         for (int c = 0; c < C; c++) dt_q[c] <= '0;
      end else begin
         last_q <= last_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         for (int c = 0; c < C; c++) dt_q[c] <= dt_d[c];
      end
   end

   assign pwm_out   = hi_q;
   assign pwm_out_n = lo_q;
`else
   assign pwm_out = pwm_raw_q;
`endif

endmodule

// File: tb/tb_pwm_wave_gen_mc.sv
// Directed bench for pwm_wave_gen_mc (R=6, S=6, C=3); duties measured by counting high cycles per period.
module tb_pwm_wave_gen_mc;

   localparam int R = 6;
   localparam int S = 6;
   localparam int C = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic [1:0]    mode = 2'd3;
   logic [15:0]   step_div = 16'd1;
   logic [R-1:0]  duty_fixed = '0;
   logic [C-1:0]  pwm_out;
   logic          period_tick;
   logic [S-1:0]  wave_idx;
`ifdef PWM_COMPL_EN
   logic [C-1:0]  pwm_out_n;
`endif

   int checks = 0;
   int errors = 0;
   int hi [C];
   int hi_n [C];
   int both;
   int cyc;
   int total;

   always #5 clk = ~clk;

   pwm_wave_gen_mc #(.R(R), .S(S), .C(C), .PHASE_STEP(21), .DT(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .mode       (mode),
      .step_div   (step_div),
      .duty_fixed (duty_fixed),
      .pwm_out    (pwm_out),
`ifdef PWM_COMPL_EN
      .pwm_out_n  (pwm_out_n),
`endif
      .period_tick(period_tick),
      .wave_idx   (wave_idx)
   );

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Advance to the next cycle with period_tick high; n = negedges taken.
   task automatic tick_wait(input string tag, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_tick && n < 200);
      check(tag, int'(period_tick), 1);
   endtask

   // Called in a tick cycle: count highs over the next full period, which ends
   // on the following tick cycle. Optionally changes duty_fixed mid-period.
   task automatic measure(input int chg_at, input logic [R-1:0] chg_val);
      for (int c = 0; c < C; c++) begin
         hi[c]   = 0;
         hi_n[c] = 0;
      end
      both = 0;
      for (int i = 0; i < 64; i++) begin
         if (i == chg_at) duty_fixed = chg_val;
         @(negedge clk);
         for (int c = 0; c < C; c++) begin
            hi[c] += int'(pwm_out[c]);
`ifdef PWM_COMPL_EN
            hi_n[c] += int'(pwm_out_n[c]);
            both    += int'(pwm_out[c] & pwm_out_n[c]);
`endif
         end
      end
   endtask

   task automatic hold_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      // Reset with en high: outputs stay cleared.
      en = 1'b1;
      mode = 2'd3;
      duty_fixed = 6'd16;
      step_div = 16'd1;
      hold_reset();
      check("rst pwm_out", int'(pwm_out), 0);
      check("rst wave_idx", int'(wave_idx), 0);
      check("rst period_tick", int'(period_tick), 0);
`ifdef PWM_COMPL_EN
      check("rst pwm_out_n", int'(pwm_out_n), 0);
`endif
      rst_n = 1'b1;
      // The release cycle is cnt=0, so the tick arrives 63 negedges later (64th cycle).
      tick_wait("first tick", cyc);
      check("first tick latency", cyc, 63);
      check("idx after tick1", int'(wave_idx), 1);

`ifdef PWM_COMPL_EN
      measure(-1, '0);
      for (int c = 0; c < C; c++) begin
         check($sformatf("compl hi ch%0d", c), hi[c], 14);
         check($sformatf("compl lo ch%0d", c), hi_n[c], 46);
      end
      check("compl overlap", both, 0);
`else
      // Fixed duty 16 on all channels.
      measure(-1, '0);
      for (int c = 0; c < C; c++) check($sformatf("fixed16 ch%0d", c), hi[c], 16);
      // Duty 0: the period already shadowed still shows 16.
      duty_fixed = 6'd0;
      measure(-1, '0);
      check("shadow keeps 16", hi[0], 16);
      measure(-1, '0);
      for (int c = 0; c < C; c++) check($sformatf("fixed0 ch%0d", c), hi[c], 0);
      duty_fixed = 6'd63;
      measure(-1, '0);
      check("shadow keeps 0", hi[2], 0);
      measure(-1, '0);
      for (int c = 0; c < C; c++) check($sformatf("fixed63 ch%0d", c), hi[c], 63);

      // Mid-period change 16 -> 48 only shows up a period later.
      duty_fixed = 6'd16;
      measure(-1, '0);
      measure(20, 6'd48);
      check("midchg keeps 16", hi[1], 16);
      measure(-1, '0);
      check("midchg shows 48", hi[1], 48);
      check("idx after 9 ticks", int'(wave_idx), 9);

      // Disable for 10 cycles mid-period.
      repeat (20) @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("dis pwm_out", int'(pwm_out), 0);
         check("dis period_tick", int'(period_tick), 0);
         check("dis wave_idx", int'(wave_idx), 9);
      end
      en = 1'b1;
      tick_wait("reenable tick", cyc);
      check("reenable latency", cyc, 63);
      check("idx after reenable", int'(wave_idx), 10);
      measure(-1, '0);
      check("reenable duty", hi[0], 48);

      // Sine with step_div=2.
      mode = 2'd0;
      step_div = 16'd2;
      hold_reset();
      rst_n = 1'b1;
      tick_wait("sine tick1", cyc);
      check("sine idx tick1", int'(wave_idx), 0);
      measure(-1, '0);
      check("sine k0", hi[0], 32);
      check("sine k21", hi[1], 59);
      check("sine k42", hi[2], 5);
      check("sine idx tick2", int'(wave_idx), 1);
      total = 0;
      tick_wait("sine tick3", cyc);
      total += cyc;
      tick_wait("sine tick4", cyc);
      total += cyc;
      check("idx step 128 cycles", total, 128);
      check("sine idx tick4", int'(wave_idx), 2);
      for (int i = 5; i <= 33; i++) tick_wait("sine run", cyc);
      check("sine idx tick33", int'(wave_idx), 16);
      measure(-1, '0);
      check("sine k16", hi[0], 63);
      check("sine k37", hi[1], 17);
      check("sine k58", hi[2], 14);

      // Now at tick34 (idx 17, hold 0). Lowering step_div under hold forces an advance.
      step_div = 16'd5;
      tick_wait("div tick35", cyc);
      tick_wait("div tick36", cyc);
      tick_wait("div tick37", cyc);
      check("div hold idx", int'(wave_idx), 17);
      step_div = 16'd2;
      tick_wait("div tick38", cyc);
      check("div lowered idx", int'(wave_idx), 18);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_wave_gen_mc.md
Name: pwm_wave_gen_mc

Overview:
- Multi-channel PWM waveform generator that drives a periodic modulation pattern (sine, triangle, sawtooth or fixed duty) onto C PWM outputs.
- Each channel runs at a programmable phase offset from the others.
- Parametrised in resolution, table depth and channel count.
- Duty updates are glitch-free: they are shadowed and take effect only at PWM period boundaries.
- Sits between the control register block and the pad drivers for LEDs, motors or audio.

Parameters:
- R, 6: PWM counter/duty resolution in bits; PWM period is 2^R clk cycles.
- S, 6: waveform index width; one waveform cycle has 2^S steps; sine table has 2^S entries.
- C, 3: number of PWM channels.
- PHASE_STEP, 21: index offset between adjacent channels; channel c uses idx + c*PHASE_STEP mod 2^S.
- DT, 2: dead-time in clk cycles; used only with the optional feature.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: run enable.
- mode, input, 2: waveform select; 0 = sine, 1 = triangle, 2 = sawtooth, 3 = fixed.
- step_div, input, 16: number of PWM periods per waveform step; a value of 0 is treated as 1.
- duty_fixed, input, R: duty used by all channels in mode 3.
- pwm_out, output, C: PWM outputs, bit c = channel c.
- period_tick, output, 1: one-cycle pulse on the last cycle of each PWM period.
- wave_idx, output, S: current base waveform index (channel 0).

Behaviour:
- Reset, asynchronous while rst_n=0: cnt, hold counter, idx and all duty shadows are 0; pwm_out=0, period_tick=0, wave_idx=0.
- PWM counter cnt (R bits):
  - en=1: increments each clk and wraps 2^R-1 -> 0.
  - en=0: cnt is forced to 0, idx and hold counter are held, pwm_out=0, period_tick=0.
  - Re-asserting en starts a fresh period at cnt=0.
- period_tick: registered; equals 1 in the cycle where cnt == 2^R-1 and en=1.
- Hold counter (16 bits): increments on each period_tick.
  - When hold+1 >= max(step_div,1): hold -> 0 and idx -> idx+1 mod 2^S (wraps 2^S-1 -> 0).
  - Because the comparison is >=, lowering step_div below the current hold count advances idx on the next tick.
- Sample value per channel: k_c = idx + c*PHASE_STEP mod 2^S, then by mode:
  - sine: lut[k_c] = round((2^R-1)*(0.5+0.5*sin(2*pi*k_c/2^S))).
  - triangle: t = k_c[S-1] ? ~k_c[S-2:0] : k_c[S-2:0]; value = t scaled from S-1 bits to R bits (left shift by R-S+1, or right shift if negative).
  - sawtooth: k_c scaled from S bits to R bits.
  - fixed: duty_fixed.
- Shadowing:
  - duty_q[c] is loaded from the sample value on the same edge as period_tick.
  - mode, duty_fixed and idx changes are therefore seen only from the next period start.
  - Duty never changes mid-period.
- Output: pwm_out[c] is registered: pwm_out[c] <= en && (cnt < duty_q[c]).
  - One clk latency relative to cnt.
  - duty_q = 0 gives a constant 0.
  - duty_q = 2^R-1 gives high for 2^R-1 of 2^R cycles; 100% duty is not reachable.
- Simultaneous events: step_div change coincident with period_tick uses the new value. Reset mid-period aborts immediately with no partial pulse.

Optional Feature:
- Macro PWM_COMPL_EN.
- Defined:
  - Adds output pwm_out_n [C-1:0], the complement of pwm_out with dead-time insertion.
  - On either edge of raw pwm[c], both pwm_out[c] and pwm_out_n[c] stay 0 for DT cycles, then the newly active side asserts.
  - Dead-time is implemented with a per-channel down-counter.
  - Pulses shorter than DT are swallowed on that side.
  - Reset: pwm_out_n=0.
- Undefined: no pwm_out_n port, no dead-time logic; pwm_out timing is exactly as in Behaviour.

Decomposition:
- Package pwm_pkg holds:
  - mode encodings MODE_SINE=0, MODE_TRI=1, MODE_SAW=2, MODE_FIXED=3.
  - the scale-shift helper function.
- Sub-module pwm_sine_lut: combinational, parameters R and S, input k [S-1:0], output value [R-1:0].
  - Table generated at elaboration from the formula above.
  - Instantiated once per channel.

Test Plan (R=6, S=6, C=3, PHASE_STEP=21, DT=2):
1. Reset: rst_n low with en=1 -> pwm_out=0, wave_idx=0; release -> first period_tick 64 cycles later.
2. mode=3, duty_fixed=16 -> each channel high exactly 16 of 64 cycles. duty_fixed=0 -> always low. duty_fixed=63 -> high 63 of 64 cycles.
3. mode=0, step_div=2 -> wave_idx advances every 128 cycles. Channel 0 duty at idx=0 is 32 and at idx=16 is 63. Channels 1 and 2 use k=21 and k=42.
4. Change duty_fixed from 16 to 48 mid-period -> current period keeps 16; next period shows 48.
5. en low for 10 cycles mid-period -> pwm_out=0 and wave_idx frozen; after re-enable, period restarts at cnt=0.
6. With PWM_COMPL_EN, duty 16 -> pwm_out high for 14 cycles, pwm_out_n high for 46 cycles, 2-cycle gaps at each transition, never both high.
